dec_sel_sequencer: RTL and testbench

Registered 3-bit select generator that drives the `w` select and `en` enable inputs of the downstream 3-to-8 decoder / function-output stage. It steps a 3-bit code up or down at a programmable rate, either continuously or for one full 8-code sweep. It also supports a synchronous parallel load. Every output is a flop, so the decoder always sees glitch-free, one-clock-aligned select/enable pairs.

---
 rtl/dec_sel_sequencer.sv | 131 +++++++++++++
 tb/tb_dec_sel_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer: registered 3-bit select/enable generator for the
// downstream 3-to-8 decoder. Steps a code up or down every DIV clocks,
// either continuously or (ONESHOT=1) for one full 8-code sweep, and
// supports a synchronous parallel load.
//
// Build option: define SEQ_GRAY_OUT_EN to drive `w` as a reflected Gray
// code of the internal binary counter. Without it, `w` is plain binary.
// Stepping, wrap detection and load_val always work on the binary code.

module dec_sel_sequencer #(
    parameter int DIV     = 1,
    parameter bit ONESHOT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic [2:0] w,
    output logic       en,
    output logic       wrap,
    output logic       done
);

    // Prescaler width; a DIV of 1 still gets a one-bit register so the
    // comparison below stays well formed.
    localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nx;
    logic [2:0]    bin;
    logic [2:0]    bin_nx;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nx;
    logic [2:0]    nstep;
    logic [2:0]    nstep_nx;
    logic          wrap_nx;
    logic          done_nx;
    logic          step;
    logic [2:0]    w_nx;

    // Next-state logic: FSM transitions, prescaler, stepping, then load,
    // which overrides any step that falls on the same edge.
    always_comb begin
        state_nx = state;
        bin_nx   = bin;
        pre_nx   = pre;
        nstep_nx = nstep;
        wrap_nx  = 1'b0;
        done_nx  = 1'b0;
        step     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx = RUN;
                    pre_nx   = '0;
                    nstep_nx = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (pre == PRE_MAX) begin
                    step   = 1'b1;
                    pre_nx = '0;
                end else begin
                    pre_nx = pre + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (load) begin
            bin_nx = load_val;
            pre_nx = '0;
        end else if (step) begin
            bin_nx  = dir ? (bin + 3'd1) : (bin - 3'd1);
            wrap_nx = dir ? (bin == 3'd7) : (bin == 3'd0);
            if (ONESHOT) begin
                nstep_nx = nstep + 3'd1;
                if (nstep == 3'd7) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
        end
    end

    // Output encoding of the next binary code for the decoder select.
    always_comb begin
`ifdef SEQ_GRAY_OUT_EN
        w_nx = bin_nx ^ (bin_nx >> 1);
`else
        w_nx = bin_nx;
`endif
    end

    // State and output registers; every output is a flop so the decoder
    // sees aligned, glitch-free select/enable pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bin   <= '0;
            pre   <= '0;
            nstep <= '0;
            w     <= '0;
            en    <= 1'b0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            bin   <= bin_nx;
            pre   <= pre_nx;
            nstep <= nstep_nx;
            w     <= w_nx;
            en    <= (state_nx == RUN);
            wrap  <= wrap_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Testbench for dec_sel_sequencer. Three instances (DIV=1 free-running,
// DIV=3 free-running, DIV=2 one-shot) share one set of inputs; each is
// tracked by its own behavioural model, plus table vectors and directed
// sequences for the multi-cycle corner cases.

module tb_dec_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;

    logic [2:0] w_o    [3];
    logic       en_o   [3];
    logic       wrap_o [3];
    logic       done_o [3];

    int checks = 0;
    int errors = 0;

    // Per-instance configuration and model state.
    int div_of [3] = '{1, 3, 2};
    bit os_of  [3] = '{1'b0, 1'b0, 1'b1};
    bit m_run  [3];
    int m_code [3];
    int m_cnt  [3];
    int m_nst  [3];
    int e_w    [3];
    int e_en   [3];
    int e_wrap [3];
    int e_done [3];

    typedef struct {
        bit       start;
        bit       stop;
        bit       dir;
        bit       load;
        bit [2:0] lv;
        int       exp_code;
        bit       exp_en;
        bit       exp_wrap;
        bit       exp_done;
    } vec_t;

    vec_t vecs [12];

    dec_sel_sequencer #(.DIV(1), .ONESHOT(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .load(load), .load_val(load_val),
        .w(w_o[0]), .en(en_o[0]), .wrap(wrap_o[0]), .done(done_o[0])
    );

    dec_sel_sequencer #(.DIV(3), .ONESHOT(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .load(load), .load_val(load_val),
        .w(w_o[1]), .en(en_o[1]), .wrap(wrap_o[1]), .done(done_o[1])
    );

    dec_sel_sequencer #(.DIV(2), .ONESHOT(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .load(load), .load_val(load_val),
        .w(w_o[2]), .en(en_o[2]), .wrap(wrap_o[2]), .done(done_o[2])
    );

    always #5 clk = ~clk;

    // Select value the decoder should see for a given code position.
    function automatic int to_w(int code);
`ifdef SEQ_GRAY_OUT_EN
        int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
        return gray_tab[code];
`else
        return code;
`endif
    endfunction

    // Behavioural model: a running flag, a code position 0..7, cycles
    // elapsed since the last step, and the number of steps in this sweep.
    function automatic void model_update(int i);
        int raw;
        if (rst) begin
            m_run[i]  = 1'b0;
            m_code[i] = 0;
            m_cnt[i]  = 0;
            m_nst[i]  = 0;
            e_wrap[i] = 0;
            e_done[i] = 0;
        end else begin
            e_wrap[i] = 0;
            e_done[i] = 0;
            if (!m_run[i]) begin
                if (start && !stop) begin
                    m_run[i] = 1'b1;
                    m_cnt[i] = 0;
                    m_nst[i] = 0;
                end
            end else if (stop) begin
                m_run[i] = 1'b0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == div_of[i] && !load) begin
                    raw       = m_code[i] + (dir ? 1 : -1);
                    e_wrap[i] = (raw < 0 || raw > 7) ? 1 : 0;
                    m_code[i] = (raw + 8) % 8;
                    m_cnt[i]  = 0;
                    if (os_of[i]) begin
                        m_nst[i] = m_nst[i] + 1;
                        if (m_nst[i] == 8) begin
                            m_run[i]  = 1'b0;
                            e_done[i] = 1;
                        end
                    end
                end
            end
            if (load) begin
                m_code[i] = int'(load_val);
                m_cnt[i]  = 0;
            end
        end
        e_w[i]  = to_w(m_code[i]);
        e_en[i] = m_run[i] ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Compare every instance against its model.
    task automatic check_output();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.w", i),    int'(w_o[i]),    e_w[i]);
            chk($sformatf("u%0d.en", i),   int'(en_o[i]),   e_en[i]);
            chk($sformatf("u%0d.wrap", i), int'(wrap_o[i]), e_wrap[i]);
            chk($sformatf("u%0d.done", i), int'(done_o[i]), e_done[i]);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_update(i);
        @(negedge clk);
        check_output();
    endtask

    task automatic apply_stimulus(input bit s_start, input bit s_stop,
                                  input bit s_dir, input bit s_load,
                                  input bit [2:0] s_lv);
        start    = s_start;
        stop     = s_stop;
        dir      = s_dir;
        load     = s_load;
        load_val = s_lv;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int en_cycles;
    bit fell;
`ifdef SEQ_GRAY_OUT_EN
    logic [2:0] prev_w;
`endif

    initial begin
        // Vector table for the DIV=1 free-running instance.
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 0, 1'b1, 1'b0, 1'b0};
        for (int r = 1; r <= 9; r++) begin
            vecs[r] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, r % 8, 1'b1, (r == 8), 1'b0};
        end
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1, 1'b0, 1'b0, 1'b0};

        // Reset state.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset.u%0d.w", i),  int'(w_o[i]),  0);
            chk($sformatf("reset.u%0d.en", i), int'(en_o[i]), 0);
        end

        // Continuous up-count with DIV=1, then stop.
        for (int r = 0; r < 12; r++) begin
            apply_stimulus(vecs[r].start, vecs[r].stop, vecs[r].dir,
                           vecs[r].load, vecs[r].lv);
            tick();
            chk($sformatf("vec%0d.w", r),    int'(w_o[0]),    to_w(vecs[r].exp_code));
            chk($sformatf("vec%0d.en", r),   int'(en_o[0]),   int'(vecs[r].exp_en));
            chk($sformatf("vec%0d.wrap", r), int'(wrap_o[0]), int'(vecs[r].exp_wrap));
            chk($sformatf("vec%0d.done", r), int'(done_o[0]), int'(vecs[r].exp_done));
        end

        // DIV=3 down-count from a loaded 2: 2,2,2,1,1,1,0,0,0,7 with wrap.
        do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        chk("down.start.w", int'(w_o[1]), to_w(2));
        chk("down.start.en", int'(en_o[1]), 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        begin
            int exp_seq [9] = '{2, 2, 1, 1, 1, 0, 0, 0, 7};
            for (int t = 0; t < 9; t++) begin
                tick();
                chk($sformatf("down.t%0d.w", t), int'(w_o[1]), to_w(exp_seq[t]));
                chk($sformatf("down.t%0d.wrap", t), int'(wrap_o[1]), (t == 8) ? 1 : 0);
            end
        end

        // One-shot sweep, DIV=2, from a loaded 5.
        do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        en_cycles = (en_o[2] == 1'b1) ? 1 : 0;
        fell = 1'b0;
        for (int t = 0; t < 40 && !fell; t++) begin
            tick();
            if (en_o[2] == 1'b1) begin
                en_cycles = en_cycles + 1;
            end else begin
                fell = 1'b1;
                chk("oneshot.done_at_fall", int'(done_o[2]), 1);
                chk("oneshot.w_end", int'(w_o[2]), to_w(5));
            end
        end
        chk("oneshot.en_fell", int'(fell), 1);
        chk("oneshot.en_cycles", en_cycles, 16);
        tick();
        chk("oneshot.done_one_cycle", int'(done_o[2]), 0);

        // Stop on the edge a step is due: no step, w holds.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        chk("stop.en", int'(en_o[1]), 0);
        chk("stop.w_hold", int'(w_o[1]), to_w(0));
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        chk("start_stop.en", int'(en_o[1]), 0);

        // Load coincident with a due step, then reset mid-sweep.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd6);
        tick();
        chk("loadstep.w", int'(w_o[1]), to_w(6));
        chk("loadstep.wrap", int'(wrap_o[1]), 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        tick();
        chk("loadstep.hold", int'(w_o[1]), to_w(6));
        tick();
        chk("loadstep.next", int'(w_o[1]), to_w(7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst.u%0d.w", i),  int'(w_o[i]),  0);
            chk($sformatf("midrst.u%0d.en", i), int'(en_o[i]), 0);
        end

`ifdef SEQ_GRAY_OUT_EN
        // Gray output: exactly one select bit changes per step.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        prev_w = w_o[0];
        for (int t = 0; t < 8; t++) begin
            tick();
            chk($sformatf("gray.t%0d.hamming", t), $countones(w_o[0] ^ prev_w), 1);
            prev_w = w_o[0];
        end
`endif

        // Randomized traffic against the models.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            apply_stimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                           1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
                           3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
